ka750_wcs: RTL and testbench

//  Writable control store (WCS) for the KA750 micro-sequencer: the responder end of the CS address/microword interface.

---
 rtl/ka750_wcs_if.sv | 51 +++++
 rtl/ka750_wcs.sv | 149 ++++++++++++++
 tb/tb_ka750_wcs.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ka750_wcs_if.sv
// ka750_wcs_if: CS microword bus (sequencer side) and console/UBI load bus
// for the KA750 writable control store.
//   master : sequencer/console end, drives addresses, read enable and load strobes
//   slave  : control store end, returns microword fields and load status
interface ka750_wcs_if;
  logic [13:0] cs_addr_h;
  logic        cs_rd_en_h;

  logic [5:0]  cs_but_h;
  logic [1:0]  cs_dtype_h;
  logic [4:0]  cs_msrc_h;
  logic [5:0]  cs_rsrc_h;
  logic [5:0]  cs_rot_h;
  logic [9:0]  cs_alpctl_h;
  logic [1:0]  cs_spw_h;
  logic [1:0]  cs_par_h;
  logic [1:0]  cs_cc_h;
  logic        cs_istrm_h;
  logic [1:0]  cs_lit_h;
  logic [4:0]  cs_misc_h;
  logic        cs_clkx_h;
  logic [5:0]  cs_next_h;
  logic        cs_jsr_h;
  logic [5:0]  cs_wctrl_h;
  logic        cs_hnext_par_h;
  logic        cs_hit_l;
  logic        cs_stall_h;

  logic        ld_adr_wr_h;
  logic        ld_dat_wr_h;
  logic [15:0] xbuf_h;
  logic        ld_ready_h;
  logic        ld_ack_h;
  logic [13:0] ld_ptr_h;

  modport master (
    output cs_addr_h, cs_rd_en_h, ld_adr_wr_h, ld_dat_wr_h, xbuf_h,
    input  cs_but_h, cs_dtype_h, cs_msrc_h, cs_rsrc_h, cs_rot_h, cs_alpctl_h,
           cs_spw_h, cs_par_h, cs_cc_h, cs_istrm_h, cs_lit_h, cs_misc_h,
           cs_clkx_h, cs_next_h, cs_jsr_h, cs_wctrl_h, cs_hnext_par_h,
           cs_hit_l, cs_stall_h, ld_ready_h, ld_ack_h, ld_ptr_h
  );

  modport slave (
    input  cs_addr_h, cs_rd_en_h, ld_adr_wr_h, ld_dat_wr_h, xbuf_h,
    output cs_but_h, cs_dtype_h, cs_msrc_h, cs_rsrc_h, cs_rot_h, cs_alpctl_h,
           cs_spw_h, cs_par_h, cs_cc_h, cs_istrm_h, cs_lit_h, cs_misc_h,
           cs_clkx_h, cs_next_h, cs_jsr_h, cs_wctrl_h, cs_hnext_par_h,
           cs_hit_l, cs_stall_h, ld_ready_h, ld_ack_h, ld_ptr_h
  );
endinterface

// File: rtl/ka750_wcs.sv
// ka750_wcs: KA750 writable control store.
// Registered 64-bit microword read (1-clock latency) for CS addresses in
// WCS_BASE .. WCS_BASE+2**AW-1, loaded as four 16-bit slices per word through
// an auto-incrementing load pointer.
// Optional build macro WCS_PARGEN_EN: regenerate par[1:0] at commit time.
//
// state  | meaning
// IDLE   | no partial word staged, next data strobe is slice 0
// FILL   | slices 1..3 being collected into the staging word
// COMMIT | staged word written to RAM, pointer advances; strobes ignored
module ka750_wcs #(
  parameter int          AW       = 10,
  parameter logic [13:0] WCS_BASE = 14'h2000
) (
  input logic        base_clock_h,
  input logic        sac_reset_l,
  ka750_wcs_if.slave bus
);

  localparam logic [14:0] WIN_SIZE = 15'(1) << AW;

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} ld_state_e;

  ld_state_e    state_q, state_d;
  logic [1:0]   slice_q, slice_d;
  logic [63:0]  stage_q, stage_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic         ack_q, ack_d;
  logic [63:0]  word_q;
  logic         hit_l_q;
  logic [63:0]  commit_word;
  logic [63:0]  mem [2**AW];

  logic         commit;
  logic [13:0]  rd_off;
  logic [13:0]  adr_off;
  logic         rd_in_win;
  logic         adr_in_win;

  assign commit     = (state_q == COMMIT);
  assign rd_off     = bus.cs_addr_h - WCS_BASE;
  assign adr_off    = bus.xbuf_h[13:0] - WCS_BASE;
  assign rd_in_win  = ({1'b0, rd_off}  < WIN_SIZE);
  assign adr_in_win = ({1'b0, adr_off} < WIN_SIZE);

  // Load FSM state and staging registers
  always_ff @(posedge base_clock_h or negedge sac_reset_l) begin
    if (!sac_reset_l) begin
      state_q <= IDLE;
      slice_q <= 2'd0;
      stage_q <= 64'd0;
      ptr_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slice_q <= slice_d;
      stage_q <= stage_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
    end
  end

  // Load FSM next state: address strobe beats data strobe, nothing accepted in COMMIT
  always_comb begin
    state_d = state_q;
    slice_d = slice_q;
    stage_d = stage_q;
    ptr_d   = ptr_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE, FILL: begin
        if (bus.ld_adr_wr_h) begin
          ptr_d   = adr_in_win ? adr_off[AW-1:0] : '0;
          slice_d = 2'd0;
          stage_d = 64'd0;
          state_d = IDLE;
          ack_d   = 1'b1;
        end else if (bus.ld_dat_wr_h) begin
          stage_d[{slice_q, 4'b0000} +: 16] = bus.xbuf_h;
          slice_d = slice_q + 2'd1;
          state_d = (slice_q == 2'd3) ? COMMIT : FILL;
          ack_d   = 1'b1;
        end
      end
      COMMIT: begin
        ptr_d   = ptr_q + 1'b1;
        slice_d = 2'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word written at commit, optionally with regenerated parity bits
  always_comb begin
    commit_word = stage_q;
`ifdef WCS_PARGEN_EN
    commit_word[37] = ^{stage_q[36:0], stage_q[40:39]};
    commit_word[38] = ^stage_q[62:41];
`endif
  end

  // Single-port RAM write; contents intentionally not reset
  always_ff @(posedge base_clock_h) begin
    if (commit)
      mem[ptr_q] <= commit_word;
  end

  // Microword read register; a commit steals the port so the read is dropped
  always_ff @(posedge base_clock_h or negedge sac_reset_l) begin
    if (!sac_reset_l) begin
      word_q  <= 64'd0;
      hit_l_q <= 1'b1;
    end else if (bus.cs_rd_en_h && !commit) begin
      if (rd_in_win) begin
        word_q  <= mem[rd_off[AW-1:0]];
        hit_l_q <= 1'b0;
      end else begin
        word_q  <= 64'd0;
        hit_l_q <= 1'b1;
      end
    end
  end

  assign bus.cs_but_h       = word_q[5:0];
  assign bus.cs_dtype_h     = word_q[7:6];
  assign bus.cs_msrc_h      = word_q[12:8];
  assign bus.cs_rsrc_h      = word_q[18:13];
  assign bus.cs_rot_h       = word_q[24:19];
  assign bus.cs_alpctl_h    = word_q[34:25];
  assign bus.cs_spw_h       = word_q[36:35];
  assign bus.cs_par_h       = word_q[38:37];
  assign bus.cs_cc_h        = word_q[40:39];
  assign bus.cs_istrm_h     = word_q[41];
  assign bus.cs_lit_h       = word_q[43:42];
  assign bus.cs_misc_h      = word_q[48:44];
  assign bus.cs_clkx_h      = word_q[49];
  assign bus.cs_next_h      = word_q[55:50];
  assign bus.cs_jsr_h       = word_q[56];
  assign bus.cs_wctrl_h     = word_q[62:57];
  assign bus.cs_hnext_par_h = word_q[63];
  assign bus.cs_hit_l       = hit_l_q;
  assign bus.cs_stall_h     = bus.cs_rd_en_h & commit;

  assign bus.ld_ready_h     = ~commit;
  assign bus.ld_ack_h       = ack_q;
  assign bus.ld_ptr_h       = WCS_BASE + 14'(ptr_q);

endmodule

// File: tb/tb_ka750_wcs.sv
// tb_ka750_wcs: directed bench for the KA750 writable control store.
module tb_ka750_wcs;
  logic base_clock_h;
  logic sac_reset_l;
  int   errs;
  int   checks;

  ka750_wcs_if bus ();

  ka750_wcs #(.AW(10), .WCS_BASE(14'h2000)) dut (
    .base_clock_h (base_clock_h),
    .sac_reset_l  (sac_reset_l),
    .bus          (bus.slave)
  );

  initial base_clock_h = 1'b0;
  always #5 base_clock_h = ~base_clock_h;

  task automatic tick();
    @(posedge base_clock_h);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fields();
    return {bus.cs_hnext_par_h, bus.cs_wctrl_h, bus.cs_jsr_h, bus.cs_next_h,
            bus.cs_clkx_h, bus.cs_misc_h, bus.cs_lit_h, bus.cs_istrm_h,
            bus.cs_cc_h, bus.cs_par_h, bus.cs_spw_h, bus.cs_alpctl_h,
            bus.cs_rot_h, bus.cs_rsrc_h, bus.cs_msrc_h, bus.cs_dtype_h,
            bus.cs_but_h};
  endfunction

  // Word as it should read back after being loaded
  function automatic logic [63:0] exp_word(input logic [63:0] w);
    logic [63:0] r;
    r = w;
`ifdef WCS_PARGEN_EN
    r[37] = ^{w[36:0], w[40:39]};
    r[38] = ^w[62:41];
`endif
    return r;
  endfunction

  task automatic set_adr(input logic [15:0] a);
    bus.ld_adr_wr_h = 1'b1;
    bus.xbuf_h      = a;
    tick();
    bus.ld_adr_wr_h = 1'b0;
    chk("adr_ack", 64'(bus.ld_ack_h), 64'd1);
  endtask

  task automatic put(input logic [15:0] d);
    bus.ld_dat_wr_h = 1'b1;
    bus.xbuf_h      = d;
    tick();
    bus.ld_dat_wr_h = 1'b0;
    chk("dat_ack", 64'(bus.ld_ack_h), 64'd1);
  endtask

  task automatic put4(input logic [63:0] w);
    put(w[15:0]);
    put(w[31:16]);
    put(w[47:32]);
    put(w[63:48]);
    chk("commit_ready_low", 64'(bus.ld_ready_h), 64'd0);
  endtask

  task automatic load_word(input logic [63:0] w);
    put4(w);
    tick();
    chk("post_commit_ready", 64'(bus.ld_ready_h), 64'd1);
  endtask

  task automatic rd(input logic [13:0] a);
    bus.cs_addr_h  = a;
    bus.cs_rd_en_h = 1'b1;
    tick();
    bus.cs_rd_en_h = 1'b0;
  endtask

  localparam logic [63:0] W_A  = 64'h4444_3333_2222_1111;
  localparam logic [63:0] W_T  = 64'hA5A5_5A5A_C3C3_3C3C;
  localparam logic [63:0] W_1  = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] W_2  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W_5  = 64'hCDEF_89AB_4567_0123;
  localparam logic [63:0] W_S  = 64'h1357_9BDF_2468_ACE0;
  localparam logic [63:0] W_P  = 64'h0000_0060_0000_0001;
`ifdef WCS_PARGEN_EN
  localparam logic [1:0]  PAR_P = 2'b01;
`else
  localparam logic [1:0]  PAR_P = 2'b11;
`endif

  initial begin
    errs = 0;
    checks = 0;
    sac_reset_l     = 1'b0;
    bus.cs_addr_h   = 14'd0;
    bus.cs_rd_en_h  = 1'b0;
    bus.ld_adr_wr_h = 1'b0;
    bus.ld_dat_wr_h = 1'b0;
    bus.xbuf_h      = 16'd0;
    tick();
    tick();

    // Reset state
    chk("rst_fields", fields(), 64'd0);
    chk("rst_hit_l", 64'(bus.cs_hit_l), 64'd1);
    chk("rst_stall", 64'(bus.cs_stall_h), 64'd0);
    chk("rst_ptr", 64'(bus.ld_ptr_h), 64'h2000);
    chk("rst_ready", 64'(bus.ld_ready_h), 64'd1);
    chk("rst_ack", 64'(bus.ld_ack_h), 64'd0);
    sac_reset_l = 1'b1;
    tick();

    // Basic load and read back
    set_adr(16'h2005);
    chk("ptr_set", 64'(bus.ld_ptr_h), 64'h2005);
    tick();
    chk("ack_one_cycle", 64'(bus.ld_ack_h), 64'd0);
    load_word(W_A);
    chk("ptr_incr", 64'(bus.ld_ptr_h), 64'h2006);
    rd(14'h2005);
    chk("read_2005", fields(), exp_word(W_A));
    chk("hit_2005", 64'(bus.cs_hit_l), 64'd0);

    // rd_en low holds fields and hit
    bus.cs_addr_h = 14'h0100;
    tick();
    chk("hold_fields", fields(), exp_word(W_A));
    chk("hold_hit", 64'(bus.cs_hit_l), 64'd0);

    // Pointer wrap at the top of the window, window boundaries
    set_adr(16'h23FF);
    load_word(W_T);
    chk("ptr_wrap", 64'(bus.ld_ptr_h), 64'h2000);
    rd(14'h23FF);
    chk("read_top", fields(), exp_word(W_T));
    chk("hit_top", 64'(bus.cs_hit_l), 64'd0);
    rd(14'h0100);
    chk("miss_fields", fields(), 64'd0);
    chk("miss_hit", 64'(bus.cs_hit_l), 64'd1);
    rd(14'h2005);
    rd(14'h2400);
    chk("miss_above", 64'(bus.cs_hit_l), 64'd1);
    rd(14'h2005);
    rd(14'h1FFF);
    chk("miss_below", 64'(bus.cs_hit_l), 64'd1);
    chk("miss_below_f", fields(), 64'd0);

    // Out-of-window load address forced to base
    set_adr(16'h0005);
    chk("ptr_forced", 64'(bus.ld_ptr_h), 64'h2000);

    // Read collides with commit to the same address
    set_adr(16'h2020);
    load_word(W_1);
    rd(14'h2020);
    chk("pre_collide", fields(), exp_word(W_1));
    set_adr(16'h2020);
    put4(W_2);
    bus.cs_addr_h   = 14'h2020;
    bus.cs_rd_en_h  = 1'b1;
    bus.ld_dat_wr_h = 1'b1;
    bus.xbuf_h      = 16'hFFFF;
    #1;
    chk("stall_high", 64'(bus.cs_stall_h), 64'd1);
    tick();
    bus.ld_dat_wr_h = 1'b0;
    chk("commit_strobe_no_ack", 64'(bus.ld_ack_h), 64'd0);
    chk("stall_fields_held", fields(), exp_word(W_1));
    chk("stall_clears", 64'(bus.cs_stall_h), 64'd0);
    chk("collide_ptr", 64'(bus.ld_ptr_h), 64'h2021);
    tick();
    bus.cs_rd_en_h = 1'b0;
    chk("reread_new", fields(), exp_word(W_2));

    // Partial word discarded by address strobe
    put(16'h5555);
    put(16'h6666);
    set_adr(16'h2010);
    load_word(W_5);
    chk("partial_ptr", 64'(bus.ld_ptr_h), 64'h2011);
    rd(14'h2010);
    chk("partial_word", fields(), exp_word(W_5));

    // Simultaneous address and data strobe: address wins, one ack
    bus.ld_adr_wr_h = 1'b1;
    bus.ld_dat_wr_h = 1'b1;
    bus.xbuf_h      = 16'h2030;
    tick();
    bus.ld_adr_wr_h = 1'b0;
    bus.ld_dat_wr_h = 1'b0;
    chk("both_ack", 64'(bus.ld_ack_h), 64'd1);
    chk("both_ptr", 64'(bus.ld_ptr_h), 64'h2030);
    tick();
    chk("both_single_ack", 64'(bus.ld_ack_h), 64'd0);
    load_word(W_S);
    chk("both_ptr_after", 64'(bus.ld_ptr_h), 64'h2031);
    rd(14'h2030);
    chk("both_word", fields(), exp_word(W_S));

    // Parity bits: regenerated or stored as written depending on build
    set_adr(16'h2040);
    load_word(W_P);
    rd(14'h2040);
    chk("par_field", 64'(bus.cs_par_h), 64'(PAR_P));
    chk("par_but", 64'(bus.cs_but_h), 64'h01);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
